cdr_sequencer: RTL
==================

Name: cdr_sequencer

Overview:
- Controller for the CDR decision datapath. Configures the datapath's samples-per-chip value, generates its 2-bit sub-sample phase count, resets and seeds it, and supervises acquisition, lock and loss-of-lock via its flag output.
- Delivers a framed chip stream of programmed length upstream and reports done/error.
- Sits between the receiver MAC-side control and one decision datapath instance.

Parameters:
- NB_P_W, 6, width of samples-per-chip config (o_nb_P).
- LEN_W, 12, width of chip-count config.
- NB_P_MIN, 4, minimum legal samples-per-chip.
- LOCK_CNT, 8, consecutive flagged chip windows required for lock.
- LOSS_MAX, 3, consecutive unflagged chip windows in TRACK that declare loss of lock.
- ACQ_TIMEOUT, 64, chip windows allowed in ACQ before error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_start  in  1  start pulse; honoured only in IDLE
- i_abort  in  1  abort; highest priority
- i_nb_P_cfg  in  NB_P_W  samples-per-chip request
- i_pkt_len  in  LEN_W  chips to deliver
- i_flag_dec  in  1  datapath flag pulse
- i_data_dec  in  1  datapath decided data
- o_nb_P  out  NB_P_W  latched config to datapath
- o_cnt_d  out  2  phase count to datapath
- o_dec_rst_n  out  1  datapath reset, active-low
- o_flag_seed  out  1  one-cycle seed pulse into datapath flag input
- o_data  out  1  delivered chip
- o_data_valid  out  1  one-cycle strobe per chip
- o_locked  out  1  high in TRACK
- o_busy  out  1  high whenever state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  one-cycle error pulse

Behaviour:
- Reset (i_rst=0 at a clock edge): state IDLE; all outputs 0, including o_dec_rst_n (datapath held in reset).
- o_dec_rst_n is 0 in IDLE, FLUSH and ERR; 1 in ACQ, TRACK and DONE.
- States: IDLE, FLUSH, ACQ, TRACK, DONE, ERR.
- Phase generator:
  - o_cnt_d increments mod 4 every cycle in ACQ and TRACK, and is 0 in all other states.
  - The period counter increments when o_cnt_d==3 and wraps after o_nb_P-1.
  - chip_tick is a one-cycle pulse on the wrap (o_cnt_d==3 and period==o_nb_P-1).
- IDLE:
  - i_start with i_nb_P_cfg>=NB_P_MIN and i_pkt_len!=0: latch o_nb_P and length, go to FLUSH.
  - i_start with an illegal config: go to ERR.
  - i_start in any other state is ignored.
- FLUSH: lasts exactly 2 cycles. o_flag_seed=1 on the second cycle, then go to ACQ.
- Window: the span between consecutive chip_ticks. A window is "flagged" if i_flag_dec was seen at least once. A flag coinciding with chip_tick belongs to the window closing on that tick.
- ACQ:
  - At each chip_tick: lock_cnt+1 if the window was flagged, else lock_cnt=0.
  - lock_cnt==LOCK_CNT: go to TRACK; o_locked=1 the next cycle.
  - ACQ_TIMEOUT chip_ticks without reaching lock: go to ERR.
- TRACK:
  - At each chip_tick: o_data<=i_data_dec, o_data_valid=1 for one cycle, chip_cnt+1.
  - Unflagged window: miss_cnt+1. Flagged window: miss_cnt=0.
  - chip_cnt==latched length: go to DONE. This takes priority over a simultaneous loss.
  - Otherwise miss_cnt==LOSS_MAX: go to ERR.
- DONE: o_done=1 for one cycle, then IDLE.
- ERR: o_err=1 for one cycle, then IDLE.
- i_abort in any non-IDLE state: IDLE next cycle. No o_done and no o_err. All counters cleared; o_locked=0.
- Arithmetic: counters are unsigned with no wrap beyond their terminal compares. chip_cnt is LEN_W bits; lock, miss and timeout counters are sized by clog2(param+1).
- Config is held stable from FLUSH through DONE; i_nb_P_cfg changes are ignored while busy.

Decomposition:
- Package cdr_pkg: state enum (IDLE, FLUSH, ACQ, TRACK, DONE, ERR); NB_P_W and LEN_W defaults; the shared cnt_d width constant (2).
- Sub-module cdr_phase_gen: o_cnt_d, period counter and chip_tick. Inputs: enable and nb_P.

Test Plan:
- Reset, then start with nb_P_cfg=8, pkt_len=4, and a flag every window -> FLUSH 2 cycles with seed on cycle 2; lock after 8 ticks; 4 o_data_valid strobes spaced 32 cycles apart; o_done once; back to IDLE.
- Start with nb_P_cfg=3 -> o_err pulse 1 cycle after start; o_dec_rst_n stays 0; o_busy pulses exactly one cycle.
- In ACQ, flags on 7 windows, one miss, then 8 flagged -> lock only after the 16th tick.
- In TRACK with pkt_len=100, suppress flags for 3 windows at chip 10 -> o_err on the third miss; o_locked drops.
- i_abort mid-TRACK -> IDLE next cycle; no done or err; o_cnt_d=0 and o_dec_rst_n=0.
- Suppress flags from start -> o_err after exactly 64 chip_ticks in ACQ; i_start pulses during ACQ are ignored.

Source files
------------

// File: rtl/cdr_pkg.sv
// cdr_pkg: shared state encoding and default widths for the CDR sequencer
package cdr_pkg;
  localparam int NB_P_W_DEF = 6;
  localparam int LEN_W_DEF = 12;
  localparam int CNT_D_W = 2;
  typedef enum logic [2:0] {IDLE, FLUSH, ACQ, TRACK, DONE, ERR} state_t;
endpackage

// File: rtl/cdr_if.sv
// cdr_if: MAC-side control and datapath-side signals of the CDR sequencer
interface cdr_if import cdr_pkg::*; #(
  parameter int NB_P_W = NB_P_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) ();
  logic i_start, i_abort, i_flag_dec, i_data_dec;
  logic [NB_P_W-1:0] i_nb_P_cfg, o_nb_P;
  logic [LEN_W-1:0] i_pkt_len;
  logic [CNT_D_W-1:0] o_cnt_d;
  logic o_dec_rst_n, o_flag_seed, o_data, o_data_valid, o_locked, o_busy, o_done, o_err;
  modport master (
    output i_start, i_abort, i_nb_P_cfg, i_pkt_len, i_flag_dec, i_data_dec,
    input o_nb_P, o_cnt_d, o_dec_rst_n, o_flag_seed, o_data, o_data_valid, o_locked, o_busy, o_done, o_err
  );
  modport slave (
    input i_start, i_abort, i_nb_P_cfg, i_pkt_len, i_flag_dec, i_data_dec,
    output o_nb_P, o_cnt_d, o_dec_rst_n, o_flag_seed, o_data, o_data_valid, o_locked, o_busy, o_done, o_err
  );
endinterface

// File: rtl/cdr_phase_gen.sv
// cdr_phase_gen: sub-sample phase count, samples-per-chip period counter and chip tick
module cdr_phase_gen import cdr_pkg::*; #(
  parameter int NB_P_W = NB_P_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [NB_P_W-1:0]  i_nb_P,
  output logic [CNT_D_W-1:0] o_cnt_d,
  output logic               o_chip_tick
);
  logic [CNT_D_W-1:0] r_cnt;
  logic [NB_P_W-1:0] r_per;
  logic w_ph_end, w_wrap;
  always_comb begin
    w_ph_end = r_cnt == '1;
    w_wrap = r_per == i_nb_P - NB_P_W'(1);
    o_cnt_d = i_en ? r_cnt : '0;
    o_chip_tick = i_en & w_ph_end & w_wrap;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst || !i_en) begin
      r_cnt <= '0;
      r_per <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_D_W'(1);
      if (w_ph_end) r_per <= w_wrap ? '0 : r_per + NB_P_W'(1);
    end
  end
endmodule

// File: rtl/cdr_sequencer.sv
// cdr_sequencer: configures, seeds and supervises one CDR decision datapath and frames its chip stream
module cdr_sequencer import cdr_pkg::*; #(
  parameter int NB_P_W = NB_P_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int NB_P_MIN = 4,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_MAX = 3,
  parameter int ACQ_TIMEOUT = 64
) (
  input logic i_clk,
  input logic i_rst,
  cdr_if.slave bus
);
  localparam int LK_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(LOSS_MAX + 1);
  localparam int TO_W = $clog2(ACQ_TIMEOUT + 1);
  localparam logic [LK_W-1:0] LK_END = LK_W'(LOCK_CNT);
  localparam logic [MS_W-1:0] MS_END = MS_W'(LOSS_MAX);
  localparam logic [TO_W-1:0] TO_END = TO_W'(ACQ_TIMEOUT);
  state_t r_state;
  logic [NB_P_W-1:0] r_nb_P;
  logic [LEN_W-1:0] r_len, r_chip, w_chip_nx;
  logic [LK_W-1:0] r_lock, w_lock_nx;
  logic [MS_W-1:0] r_miss, w_miss_nx;
  logic [TO_W-1:0] r_to, w_to_nx;
  logic [CNT_D_W-1:0] w_cnt_d;
  logic r_fl, r_win, r_data, r_valid, r_locked, r_busy, r_dec_rst_n, r_seed, r_done, r_err;
  logic w_act, w_tick, w_flagged, w_legal, w_abort;
  cdr_phase_gen #(.NB_P_W(NB_P_W)) u_phase_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_act),
    .i_nb_P      (r_nb_P),
    .o_cnt_d     (w_cnt_d),
    .o_chip_tick (w_tick)
  );
  always_comb begin
    w_act = r_state == ACQ || r_state == TRACK;
    w_abort = bus.i_abort && r_state != IDLE;
    w_flagged = r_win | bus.i_flag_dec;
    w_lock_nx = w_flagged ? r_lock + LK_W'(1) : '0;
    w_miss_nx = w_flagged ? '0 : r_miss + MS_W'(1);
    w_to_nx = r_to + TO_W'(1);
    w_chip_nx = r_chip + LEN_W'(1);
    w_legal = bus.i_nb_P_cfg >= NB_P_W'(NB_P_MIN) && bus.i_pkt_len != '0;
    bus.o_nb_P = r_nb_P;
    bus.o_cnt_d = w_cnt_d;
    bus.o_dec_rst_n = r_dec_rst_n;
    bus.o_flag_seed = r_seed;
    bus.o_data = r_data;
    bus.o_data_valid = r_valid;
    bus.o_locked = r_locked;
    bus.o_busy = r_busy;
    bus.o_done = r_done;
    bus.o_err = r_err;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst || w_abort) begin
      r_state <= IDLE;
      r_chip <= '0;
      r_lock <= '0;
      r_miss <= '0;
      r_to <= '0;
      r_fl <= 1'b0;
      r_win <= 1'b0;
      r_data <= 1'b0;
      r_valid <= 1'b0;
      r_locked <= 1'b0;
      r_busy <= 1'b0;
      r_dec_rst_n <= 1'b0;
      r_seed <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_seed <= 1'b0;
      // a flag on the tick cycle closes the current window, so the next one starts clean
      r_win <= w_act && !w_tick && w_flagged;
      case (r_state)
        IDLE: if (bus.i_start) begin
          r_busy <= 1'b1;
          r_state <= w_legal ? FLUSH : ERR;
          r_err <= !w_legal;
          if (w_legal) begin
            r_nb_P <= bus.i_nb_P_cfg;
            r_len <= bus.i_pkt_len;
          end
        end
        FLUSH: begin
          r_fl <= !r_fl;
          r_seed <= !r_fl;
          if (r_fl) begin
            r_state <= ACQ;
            r_dec_rst_n <= 1'b1;
          end
        end
        ACQ: if (w_tick) begin
          r_lock <= w_lock_nx;
          r_to <= w_to_nx;
          if (w_lock_nx == LK_END) begin
            r_state <= TRACK;
            r_locked <= 1'b1;
          end else if (w_to_nx == TO_END) begin
            r_state <= ERR;
            r_err <= 1'b1;
            r_dec_rst_n <= 1'b0;
          end
        end
        TRACK: if (w_tick) begin
          r_data <= bus.i_data_dec;
          r_valid <= 1'b1;
          r_chip <= w_chip_nx;
          r_miss <= w_miss_nx;
          if (w_chip_nx == r_len) begin
            r_state <= DONE;
            r_done <= 1'b1;
            r_locked <= 1'b0;
          end else if (w_miss_nx == MS_END) begin
            r_state <= ERR;
            r_err <= 1'b1;
            r_locked <= 1'b0;
            r_dec_rst_n <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
          r_dec_rst_n <= 1'b0;
          r_chip <= '0;
          r_lock <= '0;
          r_miss <= '0;
          r_to <= '0;
        end
      endcase
    end
    if (!i_rst) begin
      r_nb_P <= '0;
      r_len <= '0;
    end
  end
endmodule
